// File: rtl/lock_sequence_controller_if.sv
// Handshake bundle between signal conditioning, the lock sequencer and the
// gate/valve actuator drivers.
interface lock_sequence_controller_if;
   logic arriveSignal;
   logic departSignal;
   logic lowGateOpen;
   logic highGateOpen;
   logic fillValve;
   logic drainValve;
   logic busy;
   logic lockDone;
   logic levelHigh;
   logic arrivePending;
   logic departPending;

   modport master (
      output arriveSignal, departSignal,
      input  lowGateOpen, highGateOpen, fillValve, drainValve,
      input  busy, lockDone, levelHigh, arrivePending, departPending
   );

   modport slave (
      input  arriveSignal, departSignal,
      output lowGateOpen, highGateOpen, fillValve, drainValve,
      output busy, lockDone, levelHigh, arrivePending, departPending
   );
endinterface

// File: rtl/lock_sequence_controller.sv
// Canal lock sequencer: latches arrive/depart requests, then walks the chamber
// through PREP/ENTER/MOVE/EXIT with gate and valve outputs decoded from state.
module lock_sequence_controller #(
   parameter int ENTER_CYCLES = 4,
   parameter int LEVEL_CYCLES = 8,
   parameter int EXIT_CYCLES  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   lock_sequence_controller_if.slave     lock_io
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ENTER,
      S_MOVE,
      S_EXIT
   } state_t;

   localparam logic [7:0] ENTER_LD = 8'(ENTER_CYCLES - 1);
   localparam logic [7:0] LEVEL_LD = 8'(LEVEL_CYCLES - 1);
   localparam logic [7:0] EXIT_LD  = 8'(EXIT_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       dir_up_q, dir_up_d;
   logic       level_q, level_d;
   logic       arr_pend_q, arr_pend_d;
   logic       dep_pend_q, dep_pend_d;
   logic       done_q, done_d;
   logic       serve_up;
   logic       start_arr;
   logic       start_dep;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         dir_up_q   <= 1'b0;
         level_q    <= 1'b0;
         arr_pend_q <= 1'b0;
         dep_pend_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dir_up_q   <= dir_up_d;
         level_q    <= level_d;
         arr_pend_q <= arr_pend_d;
         dep_pend_q <= dep_pend_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dir_up_d  = dir_up_q;
      level_d   = level_q;
      done_d    = 1'b0;
      serve_up  = 1'b0;
      start_arr = 1'b0;
      start_dep = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (arr_pend_q || dep_pend_q) begin
               // With both pending, the side matching the current level wins.
               serve_up  = arr_pend_q && (!dep_pend_q || !level_q);
               dir_up_d  = serve_up;
               start_arr = serve_up;
               start_dep = !serve_up;
               if (serve_up == level_q) begin
                  state_d = S_PREP;
                  cnt_d   = LEVEL_LD;
               end else begin
                  state_d = S_ENTER;
                  cnt_d   = ENTER_LD;
               end
            end
         end
         S_PREP: begin
            if (cnt_q == 8'd0) begin
               state_d = S_ENTER;
               cnt_d   = ENTER_LD;
               level_d = !dir_up_q;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_ENTER: begin
            if (cnt_q == 8'd0) begin
               state_d = S_MOVE;
               cnt_d   = LEVEL_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_MOVE: begin
            if (cnt_q == 8'd0) begin
               state_d = S_EXIT;
               cnt_d   = EXIT_LD;
               level_d = dir_up_q;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_EXIT: begin
            if (cnt_q == 8'd0) begin
               state_d = S_IDLE;
               cnt_d   = 8'd0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase

      // A pulse on the edge that starts service re-arms the request.
      arr_pend_d = lock_io.arriveSignal || (arr_pend_q && !start_arr);
      dep_pend_d = lock_io.departSignal || (dep_pend_q && !start_dep);
   end

   assign lock_io.busy          = (state_q != S_IDLE);
   assign lock_io.lowGateOpen   = ((state_q == S_ENTER) &&  dir_up_q) ||
                                  ((state_q == S_EXIT)  && !dir_up_q);
   assign lock_io.highGateOpen  = ((state_q == S_ENTER) && !dir_up_q) ||
                                  ((state_q == S_EXIT)  &&  dir_up_q);
   assign lock_io.fillValve     = ((state_q == S_MOVE)  &&  dir_up_q) ||
                                  ((state_q == S_PREP)  && !dir_up_q);
   assign lock_io.drainValve    = ((state_q == S_MOVE)  && !dir_up_q) ||
                                  ((state_q == S_PREP)  &&  dir_up_q);
   assign lock_io.lockDone      = done_q;
   assign lock_io.levelHigh     = level_q;
   assign lock_io.arrivePending = arr_pend_q;
   assign lock_io.departPending = dep_pend_q;

endmodule
